node_qos_arbiter: RTL and testbench
===================================

// Module: node_qos_arbiter
// PURPOSE
// - Stage-1 arbiter for one mesh-node output port (X, Y or B). Shares the port between N requesters:
//   A local inject, C x-in and C y-in. Picks one packet per cycle into a one-entry output register.
// - Arbitration order: QoS class first, round-robin within each class, and aging to prevent starvation.
// - The node instantiates one per output port, between stage-0 route compute and the C/B outputs.
// PARAMETERS
// - N_REQ       3   number of requesters; index 0=A, 1=X-in, 2=Y-in.
// - STARVE_LIM  8   lost arbitrations after which a qos=0 requester is promoted to the high class.
// - PKT_W       22  payload width = TYPE_W+2*ID_W+FLIT_W (2+6+6+8); taken from top_define.v macros.
// PORTS
// - clk       in   1            node clock, gated off when the node is power-gated.
// - rst_n     in   1            asynchronous reset, active low.
// - req_vld   in   N_REQ        per-requester valid.
// - req_qos   in   N_REQ        per-requester QoS bit; 1 = high class.
// - req_pkt   in   N_REQ*PKT_W  flattened {type,src,tgt,data}; requester i sits at [i*PKT_W +: PKT_W].
// - req_rdy   out  N_REQ        one-hot grant / accept.
// - out_vld   out  1            output register valid.
// - out_qos   out  1            QoS bit of the held packet.
// - out_pkt   out  PKT_W        held payload.
// - out_port  out  N_REQ        one-hot source requester of the held packet.
// - out_rdy   in   1            downstream accepts when out_vld and out_rdy are both 1.
// - promo_evt out  1            1-cycle pulse when a grant went to a promoted (aged) requester.
// BEHAVIOUR
// - Reset values: out_vld=0, out_qos=0, out_pkt=0, out_port=0, promo_evt=0. Both RR pointers=0, all ages=0.
// - Reset asserted mid-operation: the held packet is dropped and nothing is replayed after release.
// - Slot free: free = !out_vld || out_rdy. No grant is issued unless free=1.
// - Handshake:
//   - req_rdy is combinational from req_vld, req_qos, ages, pointers and free. It never depends on itself.
//   - A requester holds vld, qos and pkt stable until it sees rdy.
//   - req_vld=0 never receives rdy.
// - Effective class: hi[i] = req_vld[i] & (req_qos[i] | age[i]==STARVE_LIM).
//   - If any hi[i] is set, pick among hi with ptr_hi.
//   - Otherwise pick among req_vld with ptr_lo.
// - Round-robin pick: first set bit at index >= ptr, wrapping from N_REQ-1 to 0.
//   - On a grant to index g in class c: ptr_c <= (g==N_REQ-1) ? 0 : g+1. The other pointer is unchanged.
// - Latency: a grant in cycle t loads the output register, so out_vld=1 in cycle t+1.
//   - Throughput is 1 packet/cycle with out_rdy held at 1 (back-to-back, no bubble).
// - Output register on each clock:
//   - Grant: load qos, pkt, port. out_qos reflects the original req_qos, not the promoted class.
//   - Else if out_rdy: out_vld <= 0.
//   - Else: hold all outputs.
// - Aging: age[i] width $clog2(STARVE_LIM+1), saturates at STARVE_LIM.
//   - Grant to i: age[i] <= 0.
//   - req_vld[i] and a grant to some other j: age[i] <= age[i]+1 (saturating).
//   - free=0 (stall) or req_vld[i]=0: age[i] holds. A dropped request keeps its age; this is by design.
// - promo_evt registered: 1 in cycle t+1 iff the cycle-t winner had req_qos=0 and age==STARVE_LIM.
// - Simultaneous accept and grant: out_rdy=1 with out_vld=1 plus a grant means drain and reload in the same edge.
// - All requesters idle: no grant, and pointers and ages hold.
// STRUCTURE
// - node_arb_pkg:
//   - PKT_W localparam.
//   - arb_pkt_t packed struct {type,src,tgt,data}.
//   - REQ_A/REQ_X/REQ_Y index constants.
// - Sub-module rr_pick #(N): inputs req[N], ptr; outputs one-hot gnt[N] and any.
//   - Instantiated twice (hi class, lo class). Top-level mux selects hi if any_hi.
// - Top level: ages, pointers, output register, payload mux (one-hot AND-OR).
// TESTING
// - Reset: pulse rst_n low mid-packet with out_vld=1, out_rdy=0.
//   -> all outputs 0 at once; after release, the next grant is to idx 0 (ptr=0).
// - QoS priority: req_vld=3'b111, req_qos=3'b100, out_rdy=1.
//   -> grant order 2,2,2... while Y holds qos=1; A and X age by 1 per cycle.
// - RR fairness: all three vld, qos=0, out_rdy=1 for 6 cycles.
//   -> out_port sequence 001,010,100,001,010,100.
// - Starvation, STARVE_LIM=8: X qos=1 continuously, A qos=0 waiting.
//   -> A granted on the 9th cycle with promo_evt=1 next cycle, age[A]=0 after.
// - Backpressure: out_rdy=0 for 5 cycles with 2 requesters valid.
//   -> out_pkt stable, req_rdy=0, ages and ptrs frozen; out_rdy=1 -> drain and next grant in the same cycle.
// - Wrap-around: ptr_lo=2 and only A and X valid.
//   -> A wins (wrap to 0), then ptr_lo=1, so X wins next.

Source files
------------

// File: rtl/node_qos_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// node_arb_pkg
// Shared definitions for the mesh-node output-port arbiter.
//   PKT_W      : payload width {type,src,tgt,data} = 2+6+6+8 = 22
//   arb_pkt_t  : packed view of one payload
//   REQ_A/X/Y  : requester index constants (local inject, x-in, y-in)
//   rr_next    : round-robin pointer advance after a grant
// ---------------------------------------------------------------------------
package node_arb_pkg;

  localparam int TYPE_W = 2;
  localparam int ID_W   = 6;
  localparam int FLIT_W = 8;
  localparam int PKT_W  = TYPE_W + 2*ID_W + FLIT_W;

  localparam int N_REQ_DEF      = 3;
  localparam int STARVE_LIM_DEF = 8;

  localparam int REQ_A = 0;
  localparam int REQ_X = 1;
  localparam int REQ_Y = 2;

  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   tgt;
    logic [FLIT_W-1:0] data;
  } arb_pkt_t;

  // Pointer value after a grant to index g among n requesters.
  function automatic int rr_next(input int g, input int n);
    return (g == n-1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/node_qos_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Round-robin picker: returns the first set bit of req at an index >= ptr,
// wrapping from N-1 back to 0.
//   req [N]   in   candidate requests
//   ptr [PW]  in   start index of the search
//   gnt [N]   out  one-hot winner (all zero when req is empty)
//   any       out  at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  int idx;

  // Walk N positions starting at ptr; the first hit wins.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/node_qos_arbiter.sv
// ---------------------------------------------------------------------------
// node_qos_arbiter
// Stage-1 arbiter for one mesh-node output port. Shares the port between
// N_REQ requesters (0 = local inject A, 1 = x-in, 2 = y-in) and moves at most
// one packet per cycle into a one-entry output register.
//
// Arbitration: QoS class first, round-robin inside each class, and aging so a
// qos=0 requester that loses STARVE_LIM arbitrations is promoted to the high
// class until it wins.
//
// Ports
//   clk        in   node clock
//   rst_n      in   asynchronous reset, active low
//   req_vld    in   [N_REQ]        per-requester valid
//   req_qos    in   [N_REQ]        per-requester QoS (1 = high class)
//   req_pkt    in   [N_REQ*PKT_W]  requester i at [i*PKT_W +: PKT_W]
//   req_rdy    out  [N_REQ]        one-hot grant / accept
//   out_vld    out                 output register valid
//   out_qos    out                 original QoS bit of the held packet
//   out_pkt    out  [PKT_W]        held payload
//   out_port   out  [N_REQ]        one-hot source of the held packet
//   out_rdy    in                  downstream accept
//   promo_evt  out                 pulse: last grant went to an aged requester
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both 1. A requester keeps vld/qos/pkt stable until it
// sees rdy; rdy is never raised for a requester whose vld is 0, and rdy is a
// pure function of vld, qos, ages, pointers and slot-free, never of itself.
// On the output side the slot is free when it is empty or being drained this
// cycle, so drain and reload can share one edge (1 packet/cycle).
// ---------------------------------------------------------------------------
module node_qos_arbiter
  import node_arb_pkg::*;
#(
  parameter int N_REQ      = node_arb_pkg::N_REQ_DEF,
  parameter int STARVE_LIM = node_arb_pkg::STARVE_LIM_DEF,
  parameter int PKT_W      = node_arb_pkg::PKT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ-1:0]       req_qos,
  input  logic [N_REQ*PKT_W-1:0] req_pkt,
  output logic [N_REQ-1:0]       req_rdy,
  output logic                   out_vld,
  output logic                   out_qos,
  output logic [PKT_W-1:0]       out_pkt,
  output logic [N_REQ-1:0]       out_port,
  input  logic                   out_rdy,
  output logic                   promo_evt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AGE_W = $clog2(STARVE_LIM + 1);
  localparam logic [AGE_W-1:0] AGE_LIM  = AGE_W'(STARVE_LIM);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0] ptr_hi;
  logic [PTR_W-1:0] ptr_lo;
  logic [AGE_W-1:0] age [N_REQ];

  // -------------------------------------------------------------------------
  // Class formation and picking
  // -------------------------------------------------------------------------
  logic             free;
  logic [N_REQ-1:0] at_lim;
  logic [N_REQ-1:0] hi;
  logic [N_REQ-1:0] gnt_hi;
  logic [N_REQ-1:0] gnt_lo;
  logic             any_hi;
  logic             any_lo;
  logic [N_REQ-1:0] gnt;
  logic             grant_any;

  assign free = !out_vld || out_rdy;

  // A requester that has waited STARVE_LIM lost rounds competes as high class.
  always_comb begin
    at_lim = '0;
    for (int i = 0; i < N_REQ; i++) begin
      at_lim[i] = (age[i] == AGE_LIM);
    end
  end

  assign hi = req_vld & (req_qos | at_lim);

  rr_pick #(.N(N_REQ), .PW(PTR_W)) u_pick_hi (
    .req (hi),
    .ptr (ptr_hi),
    .gnt (gnt_hi),
    .any (any_hi)
  );

  rr_pick #(.N(N_REQ), .PW(PTR_W)) u_pick_lo (
    .req (req_vld),
    .ptr (ptr_lo),
    .gnt (gnt_lo),
    .any (any_lo)
  );

  // hi is a subset of req_vld, so any_lo covers every case with a winner.
  assign grant_any = free && any_lo;
  assign gnt       = grant_any ? (any_hi ? gnt_hi : gnt_lo) : '0;
  assign req_rdy   = gnt;

  // -------------------------------------------------------------------------
  // Winner payload: one-hot AND-OR mux plus winner attributes
  // -------------------------------------------------------------------------
  logic [PKT_W-1:0] win_pkt;
  logic             win_qos;
  logic             win_promo;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] next_ptr;

  always_comb begin
    win_pkt   = '0;
    win_qos   = 1'b0;
    win_promo = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_pkt   = win_pkt | ({PKT_W{gnt[i]}} & req_pkt[i*PKT_W +: PKT_W]);
      win_qos   = win_qos | (gnt[i] & req_qos[i]);
      // Promotion counts only when the win came from aging, not from qos=1.
      win_promo = win_promo | (gnt[i] & ~req_qos[i] & at_lim[i]);
      if (gnt[i]) begin
        win_idx = PTR_W'(i);
      end
    end
  end

  assign next_ptr = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);

  // -------------------------------------------------------------------------
  // Round-robin pointers: only the class that produced the grant advances.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_hi <= '0;
      ptr_lo <= '0;
    end else if (grant_any) begin
      if (any_hi) begin
        ptr_hi <= next_ptr;
      end else begin
        ptr_lo <= next_ptr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Aging: a waiting requester ages only when someone else actually wins.
  // Stalls and idle requesters hold their age; a withdrawn request keeps it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i]) begin
          age[i] <= '0;
        end else if (grant_any && req_vld[i] && !at_lim[i]) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      out_qos   <= 1'b0;
      out_pkt   <= '0;
      out_port  <= '0;
      promo_evt <= 1'b0;
    end else begin
      promo_evt <= win_promo;
      if (grant_any) begin
        out_vld  <= 1'b1;
        out_qos  <= win_qos;
        out_pkt  <= win_pkt;
        out_port <= gnt;
      end else if (out_rdy) begin
        out_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_node_qos_arbiter.sv
// ---------------------------------------------------------------------------
// tb_node_qos_arbiter
// Directed scenarios with literal expectations, followed by a randomized run.
// A behavioural model (integer ages/pointers, list search for the winner) is
// compared against every DUT output on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_node_qos_arbiter;
  import node_arb_pkg::*;

  localparam int N   = 3;
  localparam int LIM = 8;
  localparam int W   = node_arb_pkg::PKT_W;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_vld;
  logic [N-1:0]   req_qos;
  logic [N*W-1:0] req_pkt;
  logic [N-1:0]   req_rdy;
  logic           out_vld;
  logic           out_qos;
  logic [W-1:0]   out_pkt;
  logic [N-1:0]   out_port;
  logic           out_rdy;
  logic           promo_evt;

  node_qos_arbiter #(.N_REQ(N), .STARVE_LIM(LIM), .PKT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld   (req_vld),
    .req_qos   (req_qos),
    .req_pkt   (req_pkt),
    .req_rdy   (req_rdy),
    .out_vld   (out_vld),
    .out_qos   (out_qos),
    .out_pkt   (out_pkt),
    .out_port  (out_port),
    .out_rdy   (out_rdy),
    .promo_evt (promo_evt)
  );

  // -------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] new_pkt();
    arb_pkt_t p;
    p.typ  = 2'($urandom);
    p.src  = 6'($urandom);
    p.tgt  = 6'($urandom);
    p.data = 8'($urandom);
    return p;
  endfunction

  // -------------------------------------------------------------------------
  // Behavioural model, evaluated on every falling edge
  // -------------------------------------------------------------------------
  int           m_age [N];
  int           m_ptr_hi;
  int           m_ptr_lo;
  logic         m_vld;
  logic         m_qos;
  logic [W-1:0] m_pkt;
  logic [N-1:0] m_port;
  logic         m_promo;
  logic [N-1:0] rdy_q;   // grants seen this cycle, for requester pkt refresh

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_age[i] = 0;
    m_ptr_hi = 0;
    m_ptr_lo = 0;
    m_vld    = 1'b0;
    m_qos    = 1'b0;
    m_pkt    = '0;
    m_port   = '0;
    m_promo  = 1'b0;
  endtask

  initial begin
    int           w;
    int           base;
    int           idx;
    bit           any_h;
    bit           slot_free;
    logic [N-1:0] hi_m;
    logic [N-1:0] exp_rdy;
    model_reset();
    rdy_q = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        rdy_q = '0;
        chk("rst_out_vld",  64'(out_vld),   64'(0));
        chk("rst_out_pkt",  64'(out_pkt),   64'(0));
        chk("rst_out_port", 64'(out_port),  64'(0));
        chk("rst_promo",    64'(promo_evt), 64'(0));
      end else begin
        for (int i = 0; i < N; i++) hi_m[i] = req_vld[i] && (req_qos[i] || m_age[i] == LIM);
        any_h     = (hi_m != '0);
        slot_free = !m_vld || out_rdy;
        w         = -1;
        if (slot_free) begin
          base = any_h ? m_ptr_hi : m_ptr_lo;
          for (int k = 0; k < N; k++) begin
            idx = (base + k) % N;
            if (w < 0 && (any_h ? hi_m[idx] : req_vld[idx])) w = idx;
          end
        end
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;

        chk("req_rdy",   64'(req_rdy),   64'(exp_rdy));
        chk("out_vld",   64'(out_vld),   64'(m_vld));
        chk("out_qos",   64'(out_qos),   64'(m_qos));
        chk("out_pkt",   64'(out_pkt),   64'(m_pkt));
        chk("out_port",  64'(out_port),  64'(m_port));
        chk("promo_evt", 64'(promo_evt), 64'(m_promo));
        rdy_q = req_rdy;

        // State after the coming rising edge
        if (w >= 0) begin
          m_promo = !req_qos[w] && (m_age[w] == LIM);
          for (int i = 0; i < N; i++) begin
            if (i == w)          m_age[i] = 0;
            else if (req_vld[i]) m_age[i] = (m_age[i] + 1 > LIM) ? LIM : m_age[i] + 1;
          end
          if (any_h) m_ptr_hi = rr_next(w, N);
          else       m_ptr_lo = rr_next(w, N);
          m_vld  = 1'b1;
          m_qos  = req_qos[w];
          m_pkt  = req_pkt[w*W +: W];
          m_port = exp_rdy;
        end else begin
          m_promo = 1'b0;
          if (out_rdy) m_vld = 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Advance one clock; requesters that were granted present a fresh packet.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rdy_q[i]) req_pkt[i*W +: W] = new_pkt();
    end
  endtask

  task automatic set_req(input logic [N-1:0] vld, input logic [N-1:0] qos, input logic ordy);
    req_vld = vld;
    req_qos = qos;
    out_rdy = ordy;
  endtask

  task automatic idle();
    set_req('0, '0, 1'b1);
    cyc();
    cyc();
  endtask

  task automatic do_reset();
    set_req('0, '0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Protocol-respecting random requester: a new request only once the old
  // one has been accepted (or none was pending).
  task automatic rand_cyc();
    @(posedge clk);
    #1;
    out_rdy = ($urandom_range(0, 9) < 7);
    for (int i = 0; i < N; i++) begin
      if (!req_vld[i] || rdy_q[i]) begin
        req_vld[i]         = ($urandom_range(0, 9) < 6);
        req_qos[i]         = ($urandom_range(0, 3) == 0);
        req_pkt[i*W +: W]  = new_pkt();
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [N-1:0] rr_exp [6];
  logic [W-1:0] pkt_hold;

  initial begin
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

    rst_n   = 1'b0;
    req_vld = '0;
    req_qos = '0;
    out_rdy = 1'b0;
    for (int i = 0; i < N; i++) req_pkt[i*W +: W] = new_pkt();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Reset values
    @(negedge clk);
    chk("init_out_vld",  64'(out_vld),  64'(0));
    chk("init_out_qos",  64'(out_qos),  64'(0));
    chk("init_out_port", 64'(out_port), 64'(0));
    chk("init_req_rdy",  64'(req_rdy),  64'(0));

    // Round-robin fairness with all three requesters in the low class
    cyc();
    set_req(3'b111, 3'b000, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      @(negedge clk);
      chk("rr_port", 64'(out_port), 64'(rr_exp[k]));
    end
    cyc();
    idle();

    // QoS priority: Y holds qos=1 and wins every cycle
    set_req(3'b111, 3'b100, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk("qos_port",  64'(out_port), 64'(3'b100));
      chk("qos_oqos",  64'(out_qos),  64'(1));
    end
    cyc();
    idle();

    // Reset in the middle of a held packet
    set_req(3'b001, 3'b000, 1'b0);
    cyc();
    @(negedge clk);
    chk("hold_out_vld",  64'(out_vld),  64'(1));
    chk("hold_out_port", 64'(out_port), 64'(3'b001));
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld",   64'(out_vld),   64'(0));
    chk("async_rst_qos",   64'(out_qos),   64'(0));
    chk("async_rst_pkt",   64'(out_pkt),   64'(0));
    chk("async_rst_port",  64'(out_port),  64'(0));
    chk("async_rst_promo", 64'(promo_evt), 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    set_req(3'b011, 3'b000, 1'b1);
    cyc();
    @(negedge clk);
    chk("post_rst_port", 64'(out_port), 64'(3'b001));
    cyc();

    // Starvation: X always qos=1, A qos=0 promoted after 8 losses
    do_reset();
    set_req(3'b011, 3'b010, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      @(negedge clk);
      chk("starve_port",  64'(out_port),  (k < 9) ? 64'(3'b010) : 64'(3'b001));
      chk("starve_promo", 64'(promo_evt), (k < 9) ? 64'(0) : 64'(1));
    end
    cyc();
    @(negedge clk);
    chk("starve_after_port",  64'(out_port),  64'(3'b010));
    chk("starve_after_promo", 64'(promo_evt), 64'(0));
    chk("starve_after_qos",   64'(out_qos),   64'(1));
    cyc();
    idle();

    // Backpressure: one grant, then 5 stalled cycles
    pkt_hold = req_pkt[0 +: W];
    set_req(3'b011, 3'b000, 1'b0);
    cyc();
    @(negedge clk);
    chk("bp_first_port", 64'(out_port), 64'(3'b001));
    for (int k = 0; k < 5; k++) begin
      cyc();
      @(negedge clk);
      chk("bp_req_rdy", 64'(req_rdy), 64'(0));
      chk("bp_out_pkt", 64'(out_pkt), 64'(pkt_hold));
    end
    cyc();
    out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_drain_rdy", 64'(req_rdy), 64'(3'b010));
    cyc();
    @(negedge clk);
    chk("bp_next_port", 64'(out_port), 64'(3'b010));
    chk("bp_next_vld",  64'(out_vld),  64'(1));

    // Wrap-around: ptr_lo=2, only A and X valid
    cyc();
    @(negedge clk);
    chk("wrap_a", 64'(out_port), 64'(3'b001));
    cyc();
    @(negedge clk);
    chk("wrap_x", 64'(out_port), 64'(3'b010));
    cyc();
    idle();

    // Randomized traffic with one reset in the middle
    for (int it = 0; it < 3000; it++) begin
      rand_cyc();
      if (it == 1500) begin
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
